// File: rtl/button_press_reader.sv
// Synchronises and debounces the player's button lines, then turns each
// "all released -> any pressed" transition into one graded press event.
module button_press_reader #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20,
    parameter int IDX_W           = 3
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] raw_buttons,
    input  logic [WIDTH-1:0] target,
    input  logic             enable,
    output logic [WIDTH-1:0] stable_buttons,
    output logic             press_valid,
    output logic [WIDTH-1:0] press_onehot,
    output logic [IDX_W-1:0] press_index,
    output logic             multi_press,
    output logic             hit,
    output logic             miss,
    output logic             busy
);

    typedef enum logic {IDLE, HELD} state_t;

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    state_t           state_q, state_d;
    logic             valid_q, valid_d;
    logic             hit_q, hit_d;
    logic             miss_q, miss_d;
    logic [WIDTH-1:0] onehot_q, onehot_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             multi_q, multi_d;

    logic [IDX_W-1:0] lowest;
    logic             many;
    logic             match;

    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Scan from the top so the last assignment wins with the lowest set bit.
    always_comb begin
        lowest = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (stable_q[i]) lowest = IDX_W'(i);
        end
    end

    assign many  = |(stable_q & (stable_q - WIDTH'(1)));
    assign match = (stable_q == target) && !many;

    always_comb begin
        state_d  = state_q;
        valid_d  = 1'b0;
        hit_d    = 1'b0;
        miss_d   = 1'b0;
        onehot_d = onehot_q;
        idx_d    = idx_q;
        multi_d  = multi_q;
        unique case (state_q)
            IDLE: begin
                if (|stable_q) begin
                    state_d = HELD;
                    if (enable) begin
                        valid_d  = 1'b1;
                        onehot_d = stable_q;
                        idx_d    = lowest;
                        multi_d  = many;
                        hit_d    = match;
                        miss_d   = !match;
                    end
                end
            end
            HELD: begin
                if (stable_q == '0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
            state_q  <= IDLE;
            valid_q  <= 1'b0;
            hit_q    <= 1'b0;
            miss_q   <= 1'b0;
            onehot_q <= '0;
            idx_q    <= '0;
            multi_q  <= 1'b0;
        end else begin
            sync1_q  <= raw_buttons;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
            state_q  <= state_d;
            valid_q  <= valid_d;
            hit_q    <= hit_d;
            miss_q   <= miss_d;
            onehot_q <= onehot_d;
            idx_q    <= idx_d;
            multi_q  <= multi_d;
        end
    end

    assign stable_buttons = stable_q;
    assign press_valid    = valid_q;
    assign press_onehot   = onehot_q;
    assign press_index    = idx_q;
    assign multi_press    = multi_q;
    assign hit            = hit_q;
    assign miss           = miss_q;
    assign busy           = (state_q == HELD);

endmodule

// File: tb/tb_button_press_reader.sv
// Directed bench for button_press_reader with a press-event scoreboard
// checked whenever press_valid pulses.
module tb_button_press_reader;

    logic       clk = 1'b0;
    logic       resetn;
    logic [7:0] raw_buttons;
    logic [7:0] target;
    logic       enable;
    logic [7:0] stable_buttons;
    logic       press_valid;
    logic [7:0] press_onehot;
    logic [2:0] press_index;
    logic       multi_press;
    logic       hit;
    logic       miss;
    logic       busy;

    int vectors     = 0;
    int miscompares = 0;
    int pulses      = 0;
    int base;

    typedef struct {
        logic [7:0] oh;
        logic [2:0] idx;
        logic       multi;
        logic       hit;
        logic       miss;
    } ev_t;

    ev_t sb[$];
    ev_t got;

    button_press_reader #(
        .WIDTH(8),
        .DEBOUNCE_CYCLES(4),
        .CNT_W(20),
        .IDX_W(3)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .raw_buttons(raw_buttons),
        .target(target),
        .enable(enable),
        .stable_buttons(stable_buttons),
        .press_valid(press_valid),
        .press_onehot(press_onehot),
        .press_index(press_index),
        .multi_press(multi_press),
        .hit(hit),
        .miss(miss),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] oh, input logic [2:0] idx,
                        input logic multi, input logic h);
        ev_t e;
        e.oh    = oh;
        e.idx   = idx;
        e.multi = multi;
        e.hit   = h;
        e.miss  = !h;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (resetn === 1'b1 && press_valid === 1'b1) begin
            pulses++;
            if (sb.size() == 0) begin
                chk("unexpected_pulse", 32'(press_onehot), 32'hffff_ffff);
            end else begin
                got = sb.pop_front();
                chk("ev_onehot", 32'(press_onehot), 32'(got.oh));
                chk("ev_index", 32'(press_index), 32'(got.idx));
                chk("ev_multi", 32'(multi_press), 32'(got.multi));
                chk("ev_hit", 32'(hit), 32'(got.hit));
                chk("ev_miss", 32'(miss), 32'(got.miss));
            end
        end else if (resetn === 1'b1 && (hit !== 1'b0 || miss !== 1'b0)) begin
            chk("grade_without_valid", 32'({hit, miss}), 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn      = 1'b0;
        raw_buttons = 8'h00;
        target      = 8'h00;
        enable      = 1'b1;
        step(2);
        chk("rst_stable", 32'(stable_buttons), 32'h0);
        chk("rst_valid", 32'(press_valid), 32'h0);
        chk("rst_onehot", 32'(press_onehot), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        resetn = 1'b1;
        step(2);

        // Clean press: raw changes now, E0 is the next edge.
        target      = 8'h04;
        raw_buttons = 8'h04;
        push(8'h04, 3'd2, 1'b0, 1'b1);
        step(1);
        step(4);
        chk("clean_stable_e4", 32'(stable_buttons), 32'h00);
        step(1);
        chk("clean_stable_e5", 32'(stable_buttons), 32'h04);
        chk("clean_valid_e5", 32'(press_valid), 32'h0);
        step(1);
        chk("clean_valid_e6", 32'(press_valid), 32'h1);
        chk("clean_hit", 32'(hit), 32'h1);
        chk("clean_index", 32'(press_index), 32'h2);
        chk("clean_multi", 32'(multi_press), 32'h0);
        step(1);
        chk("clean_busy", 32'(busy), 32'h1);
        chk("clean_valid_drop", 32'(press_valid), 32'h0);
        raw_buttons = 8'h00;
        step(10);
        chk("release_busy", 32'(busy), 32'h0);

        // Bounce shorter than the debounce window.
        base = pulses;
        for (int k = 0; k < 4; k++) begin
            raw_buttons = (k % 2 == 0) ? 8'h08 : 8'h00;
            step(2);
            chk("bounce_stable", 32'(stable_buttons), 32'h00);
        end
        raw_buttons = 8'h00;
        step(10);
        chk("bounce_stable_end", 32'(stable_buttons), 32'h00);
        chk("bounce_pulses", 32'(pulses - base), 32'd0);

        // Wrong single press, then a two-button press.
        target      = 8'h01;
        raw_buttons = 8'h02;
        push(8'h02, 3'd1, 1'b0, 1'b0);
        step(10);
        raw_buttons = 8'h00;
        step(10);
        raw_buttons = 8'h81;
        push(8'h81, 3'd0, 1'b1, 1'b0);
        step(10);
        chk("multi_onehot", 32'(press_onehot), 32'h81);
        raw_buttons = 8'h00;
        step(10);

        // Adding a bit while held must not create a second event.
        base        = pulses;
        target      = 8'h10;
        raw_buttons = 8'h10;
        push(8'h10, 3'd4, 1'b0, 1'b1);
        step(10);
        raw_buttons = 8'h30;
        step(10);
        chk("hold_onehot", 32'(press_onehot), 32'h10);
        chk("hold_stable", 32'(stable_buttons), 32'h30);
        raw_buttons = 8'h00;
        step(10);
        raw_buttons = 8'h10;
        push(8'h10, 3'd4, 1'b0, 1'b1);
        step(10);
        raw_buttons = 8'h00;
        step(10);
        chk("hold_pulses", 32'(pulses - base), 32'd2);

        // Press swallowed while disabled; enabling mid-hold does nothing.
        base        = pulses;
        enable      = 1'b0;
        target      = 8'h08;
        raw_buttons = 8'h08;
        step(10);
        chk("dis_busy", 32'(busy), 32'h1);
        enable = 1'b1;
        step(10);
        chk("dis_pulses_held", 32'(pulses - base), 32'd0);
        raw_buttons = 8'h00;
        step(10);
        raw_buttons = 8'h08;
        push(8'h08, 3'd3, 1'b0, 1'b1);
        step(10);
        chk("dis_pulses_repress", 32'(pulses - base), 32'd1);
        raw_buttons = 8'h00;
        step(10);

        // Asynchronous reset in the middle of a hold.
        target      = 8'h04;
        raw_buttons = 8'h04;
        push(8'h04, 3'd2, 1'b0, 1'b1);
        step(10);
        chk("pre_rst_busy", 32'(busy), 32'h1);
        #2 resetn = 1'b0;
        #1;
        chk("arst_stable", 32'(stable_buttons), 32'h0);
        chk("arst_busy", 32'(busy), 32'h0);
        chk("arst_onehot", 32'(press_onehot), 32'h0);
        chk("arst_index", 32'(press_index), 32'h0);
        chk("arst_valid", 32'(press_valid), 32'h0);
        step(2);
        resetn = 1'b1;
        push(8'h04, 3'd2, 1'b0, 1'b1);
        step(1);
        step(5);
        chk("arst_restable", 32'(stable_buttons), 32'h04);
        chk("arst_valid_e5", 32'(press_valid), 32'h0);
        step(1);
        chk("arst_valid_e6", 32'(press_valid), 32'h1);
        raw_buttons = 8'h00;
        step(10);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/button_press_reader.md
Name: button_press_reader

Overview:
- Input-side counterpart of the LED target driver. It reads the player's raw button/switch lines from the GPIO input header and synchronises and debounces each line.
- It turns each press into a single validated press event and grades that event against the currently lit target pattern.
- It replaces the combinational equality compare at the game top. The score counter and LED sequencer then advance on clean single-cycle hit/miss pulses instead of a level.

Parameters:
- WIDTH, 8, number of button lines (one per target LED).
- DEBOUNCE_CYCLES, 1000000, consecutive cycles a synchronised level must differ from the stable level before it is accepted (20 ms at 50 MHz). Must be at least 2.
- CNT_W, 20, debounce counter width; 2^CNT_W must be at least DEBOUNCE_CYCLES.
- IDX_W, 3, width of press_index; equals ceil(log2(WIDTH)).

Ports:
- clk, input, 1, system clock (CLOCK_50 at top).
- resetn, input, 1, asynchronous active-low reset.
- raw_buttons, input, WIDTH, unsynchronised button levels; 1 = pressed.
- target, input, WIDTH, current target LED pattern; sampled in the cycle of the event.
- enable, input, 1, 1 = events are emitted; 0 = presses are swallowed.
- stable_buttons, output, WIDTH, debounced button levels.
- press_valid, output, 1, one-cycle pulse per accepted press event.
- press_onehot, output, WIDTH, stable pattern captured at the last event; held until the next event.
- press_index, output, IDX_W, index of the lowest set bit of press_onehot; held.
- multi_press, output, 1, 1 if more than one bit was set at capture; held.
- hit, output, 1, one-cycle pulse coincident with press_valid.
- miss, output, 1, one-cycle pulse coincident with press_valid.
- busy, output, 1, 1 while in state HELD.

Behaviour:
- Reset (asynchronous, resetn=0):
  - Sync flops, stable_buttons, all counters, press_onehot, press_index, multi_press, press_valid, hit and miss all clear to 0.
  - State goes to IDLE; busy=0.
  - Applies at any time, including mid-debounce or mid-HELD.
- Synchronisation: two flops per bit. sync2 lags raw_buttons by 2 edges.
- Debounce, per bit with an independent counter:
  - If sync2 == stable, the counter clears to 0.
  - Otherwise, if counter == DEBOUNCE_CYCLES-1, stable <= sync2 and the counter clears.
  - Otherwise the counter increments.
  - A glitch lasting fewer than DEBOUNCE_CYCLES cycles never changes stable. The same rule applies to press and release.
- FSM, two states:
  - IDLE: if stable_buttons != 0 and enable=1, then:
    - press_valid=1 for one cycle;
    - press_onehot <= stable_buttons;
    - press_index <= lowest set bit;
    - multi_press <= (popcount > 1);
    - go to HELD.
  - IDLE: if stable_buttons != 0 and enable=0, go to HELD with no pulse and no output update.
  - HELD: stay until stable_buttons == 0, then go to IDLE. Bits that become set while in HELD are ignored. Exactly one event is produced per "all released -> any pressed" cycle.
- Grading, registered and coincident with press_valid:
  - hit = (stable_buttons == target) and multi_press == 0.
  - miss = press_valid and not hit.
  - hit and miss are mutually exclusive, and both are 0 whenever press_valid=0.
- Latency: let E0 be the first edge that samples a new raw level held steady.
  - stable updates at edge E0+DEBOUNCE_CYCLES+1.
  - press_valid is high in the cycle following edge E0+DEBOUNCE_CYCLES+2.
- Simultaneous events:
  - Bits that stabilise in the same cycle are captured together; multi_press=1, and press_index gives the lowest bit.
  - enable changing in the same cycle that stable becomes nonzero: the registered enable value seen in IDLE decides.
- Reset released while a button is held: stable starts at 0, so the held button re-debounces and produces one event.
- target changing mid-HELD has no effect; it is sampled only at the event.

Test Plan (DEBOUNCE_CYCLES=4, WIDTH=8):
- Clean press:
  - Stimulus: target=8'h04, enable=1; raw_buttons goes 8'h00 -> 8'h04 at E0 and is held.
  - Required: stable_buttons=8'h04 after edge E0+5; press_valid, hit=1, press_index=2, multi_press=0 in the cycle after edge E0+6; busy=1 afterwards.
- Bounce rejection:
  - Stimulus: raw bit 3 toggles 1,0,1,0 every 2 cycles, then stays 0.
  - Required: stable_buttons stays 8'h00; no press_valid.
- Wrong and multiple presses:
  - Stimulus: target=8'h01; raw_buttons=8'h02.
  - Required: one pulse with miss=1, press_index=1.
  - Stimulus: release, then raw_buttons=8'h81 in the same cycle.
  - Required: miss=1, multi_press=1, press_index=0, press_onehot=8'h81.
- Hold and add:
  - Stimulus: press 8'h10, then while still held add bit 5; release all; press 8'h10 again.
  - Required: exactly two press_valid pulses total; the first has press_onehot=8'h10.
- Disabled:
  - Stimulus: enable=0; press 8'h08; set enable=1 while still held; then release and re-press.
  - Required: no pulse while held; one pulse after the re-press.
- Async reset:
  - Stimulus: assert resetn=0 mid-HELD with 8'h04 held; release reset.
  - Required: all outputs 0 immediately; one new press_valid pulse 6 edges after the first edge following reset release.
